tblink_rpc_pktbuf: RTL and testbench

//  Store-and-forward packet buffer upstream of the tblink_rpc_ctrl host target port (t_).

---
 rtl/tblink_rpc_pktbuf_pkg.sv | 19 +
 rtl/tblink_rpc_pkt_parser.sv | 76 +++++++
 rtl/tblink_rpc_pktbuf.sv | 142 ++++++++++++++
 tb/tb_tblink_rpc_pktbuf.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tblink_rpc_pktbuf_pkg.sv
// Packet-format definitions shared by the tblink_rpc store-and-forward buffer
// and its packet parsers.
package tblink_rpc_pktbuf_pkg;

  localparam int PKT_HDR_BYTES = 2;

  typedef enum logic [1:0] {
    PS_ADDR    = 2'd0,
    PS_SIZE    = 2'd1,
    PS_PAYLOAD = 2'd2,
    PS_DISCARD = 2'd3
  } pkt_state_e;

  // A packet whose header plus payload cannot fit in the buffer can never be committed.
  function automatic logic pkt_oversize(input logic [7:0] size, input int depth);
    return (int'(size) + PKT_HDR_BYTES) > depth;
  endfunction

endpackage

// File: rtl/tblink_rpc_pkt_parser.sv
// Tracks packet boundaries on a byte stream: addr byte, size byte, then size payload bytes.
// Flags the last byte of each packet and, when allowed, oversize packets to be discarded.
module tblink_rpc_pkt_parser
  import tblink_rpc_pktbuf_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter bit ALLOW_DROP = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       strobe_i,
  input  logic [7:0] dat_i,
  output logic [1:0] state_o,
  output logic [7:0] size_o,
  output logic       last_o,
  output logic       drop_o
);

  pkt_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] size_q, size_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PS_ADDR;
      cnt_q   <= 8'd0;
      size_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    last_o  = 1'b0;
    drop_o  = 1'b0;
    if (strobe_i) begin
      case (state_q)
        PS_ADDR: state_d = PS_SIZE;
        PS_SIZE: begin
          size_d = dat_i;
          cnt_d  = dat_i;
          if (ALLOW_DROP && pkt_oversize(dat_i, DEPTH)) begin
            drop_o  = 1'b1;
            state_d = PS_DISCARD;
          end else if (dat_i == 8'd0) begin
            last_o  = 1'b1;
            state_d = PS_ADDR;
          end else begin
            state_d = PS_PAYLOAD;
          end
        end
        PS_PAYLOAD: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            last_o  = 1'b1;
            state_d = PS_ADDR;
          end
        end
        PS_DISCARD: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = PS_ADDR;
        end
        default: state_d = PS_ADDR;
      endcase
    end
  end

  assign state_o = state_q;
  assign size_o  = size_q;

endmodule

// File: rtl/tblink_rpc_pktbuf.sv
// Store-and-forward packet buffer in front of the tblink_rpc_ctrl target port:
// bytes are released downstream only after their whole packet has been received.
module tblink_rpc_pktbuf
  import tblink_rpc_pktbuf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        uclock,
  input  logic        reset_n,
  input  logic [7:0]  t_dat,
  input  logic        t_valid,
  output logic        t_ready,
  output logic [7:0]  i_dat,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [AW:0] pkt_cnt,
  output logic [7:0]  drop_cnt,
  output logic        err_ovf,
  input  logic        err_clr
);

  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        err_ovf_q, err_ovf_d;

  logic        full, wr_acc, wr_store, rd_acc;
  logic [1:0]  wr_state, rd_state;
  logic [7:0]  wr_size, rd_size;
  logic        wr_last, wr_drop, rd_last, rd_drop;
  logic        parser_unused;

  // Occupancy counts the uncommitted tail too, so a partial packet holds its space.
  assign full     = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
  assign t_ready  = reset_n && (!full || (wr_state == PS_DISCARD));
  assign wr_acc   = t_valid && t_ready;
  assign wr_store = wr_acc && (wr_state != PS_DISCARD);

  assign i_valid  = rd_ptr_q != cm_ptr_q;
  assign i_dat    = i_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign rd_acc   = i_valid && i_ready;

  tblink_rpc_pkt_parser #(
    .DEPTH      (DEPTH),
    .ALLOW_DROP (1'b1)
  ) u_wr_parser (
    .clk_i    (uclock),
    .rst_ni   (reset_n),
    .strobe_i (wr_acc),
    .dat_i    (t_dat),
    .state_o  (wr_state),
    .size_o   (wr_size),
    .last_o   (wr_last),
    .drop_o   (wr_drop)
  );

  tblink_rpc_pkt_parser #(
    .DEPTH      (DEPTH),
    .ALLOW_DROP (1'b0)
  ) u_rd_parser (
    .clk_i    (uclock),
    .rst_ni   (reset_n),
    .strobe_i (rd_acc),
    .dat_i    (i_dat),
    .state_o  (rd_state),
    .size_o   (rd_size),
    .last_o   (rd_last),
    .drop_o   (rd_drop)
  );

  assign parser_unused = ^{wr_size, rd_state, rd_size, rd_drop};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_ovf_d  = err_ovf_q;

    // An oversize size byte rolls back over its already-stored addr byte.
    if (wr_drop) begin
      wr_ptr_d = cm_ptr_q;
    end else if (wr_store) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (wr_last) cm_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    if (wr_drop) begin
      err_ovf_d = 1'b1;
      if (err_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      err_ovf_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= 8'd0;
      err_ovf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  always_ff @(posedge uclock) begin
    if (wr_store) mem_q[wr_ptr_q[AW-1:0]] <= t_dat;
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_tblink_rpc_pktbuf.sv
// Randomized bench for tblink_rpc_pktbuf, checked every cycle against a packet-level
// model built from byte queues and occupancy arithmetic.
module tb_tblink_rpc_pktbuf;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic        uclock  = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  t_dat   = 8'h00;
  logic        t_valid = 1'b0;
  logic        t_ready;
  logic [7:0]  i_dat;
  logic        i_valid;
  logic        i_ready = 1'b0;
  logic [AW:0] pkt_cnt;
  logic [7:0]  drop_cnt;
  logic        err_ovf;
  logic        err_clr = 1'b0;

  always #5 uclock = ~uclock;

  tblink_rpc_pktbuf #(.DEPTH(DEPTH)) dut (
    .uclock   (uclock),
    .reset_n  (reset_n),
    .t_dat    (t_dat),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .i_dat    (i_dat),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .err_ovf  (err_ovf),
    .err_clr  (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending stimulus, committed-but-unread bytes, packet bookkeeping.
  byte unsigned in_q[$];
  byte unsigned exp_q[$];
  byte unsigned cur_pkt[$];
  int           pkt_len_q[$];
  byte unsigned pkt_addr_q[$];
  int wphase, wrem, part_cnt, rd_pos, drops;
  bit err_m;

  int vprob, rprob;
  bit clr_rand, clr_on_size, clr_force;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    in_q.delete(); exp_q.delete(); cur_pkt.delete();
    pkt_len_q.delete(); pkt_addr_q.delete();
    wphase = 0; wrem = 0; part_cnt = 0; rd_pos = 0; drops = 0; err_m = 1'b0;
  endtask

  task automatic model_commit();
    foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
    pkt_len_q.push_back(cur_pkt.size());
    pkt_addr_q.push_back(cur_pkt[0]);
    part_cnt = 0;
    wphase   = 0;
  endtask

  task automatic model_write(input byte unsigned b, output bit dropped);
    dropped = 1'b0;
    case (wphase)
      0: begin cur_pkt.delete(); cur_pkt.push_back(b); part_cnt = 1; wphase = 1; end
      1: begin
        wrem = int'(b);
        if (int'(b) + 2 > DEPTH) begin
          dropped = 1'b1; part_cnt = 0; wphase = 3;
        end else begin
          cur_pkt.push_back(b); part_cnt++;
          if (b == 0) model_commit(); else wphase = 2;
        end
      end
      2: begin
        cur_pkt.push_back(b); part_cnt++; wrem--;
        if (wrem == 0) model_commit();
      end
      default: begin wrem--; if (wrem == 0) wphase = 0; end
    endcase
  endtask

  task automatic model_read();
    byte unsigned b;
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      rd_pos++;
      if (pkt_len_q.size() > 0 && rd_pos == pkt_len_q[0]) begin
        $display("[TB] pkt out addr=%02h len=%0d last=%02h", pkt_addr_q[0], pkt_len_q[0], b);
        void'(pkt_len_q.pop_front());
        void'(pkt_addr_q.pop_front());
        rd_pos = 0;
      end
    end
  endtask

  task automatic push_pkt(input byte unsigned addr, input int n);
    in_q.push_back(addr);
    in_q.push_back(8'(n));
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
  endtask

  // One clock: drive inputs, compare at negedge, advance the model by the real handshakes.
  task automatic step();
    bit wacc, racc, dropped;
    int occ;
    t_valid = (in_q.size() > 0) && ($urandom_range(99) < vprob);
    t_dat   = (in_q.size() > 0) ? in_q[0] : 8'($urandom);
    i_ready = $urandom_range(99) < rprob;
    err_clr = (clr_rand && ($urandom_range(99) < 2)) || (clr_on_size && t_valid && wphase == 1) || clr_force;
    @(negedge uclock);
    occ = exp_q.size() + part_cnt;
    check_val("t_ready", t_ready, (occ != DEPTH) || (wphase == 3));
    check_val("i_valid", i_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check_val("i_dat", i_dat, exp_q[0]);
    check_val("pkt_cnt", pkt_cnt, pkt_len_q.size());
    check_val("drop_cnt", drop_cnt, drops);
    check_val("err_ovf", err_ovf, err_m);
    wacc = t_valid && t_ready;
    racc = i_valid && i_ready;
    if (racc) model_read();
    dropped = 1'b0;
    if (wacc && in_q.size() > 0) model_write(in_q.pop_front(), dropped);
    if (dropped) begin
      err_m = 1'b1;
      drops = err_clr ? 1 : ((drops < 255) ? drops + 1 : 255);
    end else if (err_clr) begin
      err_m = 1'b0;
      drops = 0;
    end
    @(posedge uclock);
    #1;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check_val({tag, "_drained"}, (in_q.size() == 0) && (exp_q.size() == 0), 1);
  endtask

  task automatic do_reset(input string tag);
    t_valid = 1'b0; i_ready = 1'b0; err_clr = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val({tag, "_t_ready"},  t_ready,  0);
    check_val({tag, "_i_valid"},  i_valid,  0);
    check_val({tag, "_i_dat"},    i_dat,    0);
    check_val({tag, "_pkt_cnt"},  pkt_cnt,  0);
    check_val({tag, "_drop_cnt"}, drop_cnt, 0);
    check_val({tag, "_err_ovf"},  err_ovf,  0);
    model_clear();
    repeat (3) @(posedge uclock);
    @(negedge uclock);
    reset_n = 1'b1;
    @(posedge uclock);
    #1;
  endtask

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned s1[5] = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    byte unsigned s5a[4] = '{8'h01, 8'h05, 8'h11, 8'h22};
    byte unsigned s5b[3] = '{8'h33, 8'h44, 8'h55};
    int r, n;

    vprob = 100; rprob = 100; clr_rand = 0; clr_on_size = 0; clr_force = 0;
    do_reset("rst0");

    // Basic 3-byte payload packet, then a zero-length packet.
    foreach (s1[i]) in_q.push_back(s1[i]);
    drain("s1", 100);
    check_val("s1_pkt_cnt_end", pkt_cnt, 0);
    push_pkt(8'h00, 0);
    drain("s2", 100);

    // Oversize packet is swallowed; the next one passes intact.
    push_pkt(8'h02, 8'h40);
    push_pkt(8'h01, 1);
    drain("s3", 300);
    check_val("s3_drop_cnt", drop_cnt, 1);
    check_val("s3_err_ovf", err_ovf, 1);

    // Fill to exactly DEPTH bytes with the reader stalled, then release.
    rprob = 0;
    for (int i = 0; i < 10; i++) push_pkt(8'(8'h10 + i), 6);
    repeat (120) step();
    check_val("s4_stall_bytes", 80 - in_q.size(), 64);
    check_val("s4_stall_ready", t_ready, 0);
    rprob = 100;
    drain("s4", 400);

    // Partial packet must not leak out while the sender pauses.
    foreach (s5a[i]) in_q.push_back(s5a[i]);
    repeat (14) step();
    check_val("s5_held_valid", i_valid, 0);
    foreach (s5b[i]) in_q.push_back(s5b[i]);
    drain("s5", 100);

    // Reset in the middle of a payload with a committed packet pending.
    rprob = 0;
    push_pkt(8'h05, 2);
    push_pkt(8'h01, 32);
    repeat (15) step();
    check_val("s6_pre_valid", i_valid, 1);
    do_reset("rst_mid");
    rprob = 100;
    push_pkt(8'h07, 3);
    drain("s6", 100);

    // Randomized traffic with throttling on both sides and occasional error clears.
    vprob = 70; rprob = 60; clr_rand = 1;
    for (int p = 0; p < 300; p++) begin
      r = $urandom_range(99);
      if (r < 70)      n = $urandom_range(12);
      else if (r < 80) n = DEPTH - 2;
      else if (r < 88) n = DEPTH - 1;
      else             n = $urandom_range(DEPTH + 8);
      push_pkt(8'($urandom), n);
    end
    drain("rand", 40000);

    // Drop counter saturation, then a clear colliding with a fresh drop.
    vprob = 100; rprob = 100; clr_rand = 0;
    clr_force = 1; step(); clr_force = 0;
    check_val("clr_drop_cnt", drop_cnt, 0);
    check_val("clr_err_ovf", err_ovf, 0);
    for (int p = 0; p < 256; p++) push_pkt(8'hEE, DEPTH - 1);
    drain("sat", 20000);
    check_val("sat_drop_cnt", drop_cnt, 255);
    clr_on_size = 1;
    push_pkt(8'hEF, DEPTH - 1);
    drain("clr_vs_drop", 200);
    clr_on_size = 0;
    check_val("clr_vs_drop_cnt", drop_cnt, 1);
    check_val("clr_vs_drop_err", err_ovf, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
